serial_subtractor: RTL

//  Bit-serial WIDTH-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first.

---
 rtl/serial_arith_pkg.sv | 19 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks:
// FSM state encoding and a counter-width helper.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Smallest r such that 2**r >= v (0 for v <= 1).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - b_in, with borrow-out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic b_in,
   output logic d,
   output logic b_out
);

   // Difference and borrow for one bit position.
   always_comb begin
      d     = a ^ b ^ b_in;
      b_out = (~a & b) | (~(a ^ b) & b_in);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - b_in, LSB first, one bit per clock.
// One full_subtractor cell plus a borrow flip-flop; WIDTH+1 cycles of latency.
// Optional macro SERIAL_SUB_OVERFLOW_EN adds the ovf (two's-complement overflow) output.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out
`ifdef SERIAL_SUB_OVERFLOW_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state, state_next;
   logic             load, step, capture;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr;
   logic             borrow;
   logic             cell_d, cell_bo;
`ifdef SERIAL_SUB_OVERFLOW_EN
   logic             a_sign, b_sign;
`endif

   full_subtractor u_cell (
      .a     (a_sr[0]),
      .b     (b_sr[0]),
      .b_in  (borrow),
      .d     (cell_d),
      .b_out (cell_bo)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state and datapath control strobes.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt == CNT_LAST) state_next = ST_DONE;
         end
         ST_DONE: begin
            // The last result bit landed in res_sr on entry; publish it here,
            // and a start in this cycle reloads operands in the same edge.
            capture = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = ST_RUN;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // busy reflects RUN directly.
   always_comb busy = (state == ST_RUN);

   // Shift registers, borrow FF, counter and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         done   <= 1'b0;
         diff   <= '0;
         b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
         a_sign <= 1'b0;
         b_sign <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else begin
         done <= capture;
         if (capture) begin
            diff  <= res_sr;
            b_out <= borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf   <= (a_sign != b_sign) && (res_sr[WIDTH-1] != a_sign);
`endif
         end
         if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= b_in;
            cnt    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
`endif
         end else if (step) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= {cell_d, res_sr[WIDTH-1:1]};
            borrow <= cell_bo;
            cnt    <= cnt + CW'(1);
         end
      end
   end

endmodule
